// File: rtl/gear_shift_sequencer_pkg.sv
// Shared types for the gear shift sequencer: FSM states, gear codes and the
// per-gear speed ceiling used to decide whether a rev-match is needed.
package gear_shift_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    QUALIFY   = 2'd1,
    REV_MATCH = 2'd2,
    ENGAGE    = 2'd3
  } state_e;

  localparam logic [2:0] GEAR_N       = 3'd0;
  localparam logic [2:0] GEAR_R       = 3'd6;
  localparam logic [2:0] GEAR_INVALID = 3'd7;

  // Highest speed level the gear can be engaged at.
  function automatic logic [3:0] tmax(input logic [2:0] g);
    case (g)
      GEAR_N:  tmax = 4'd15;
      3'd1:    tmax = 4'd3;
      3'd2:    tmax = 4'd6;
      3'd3:    tmax = 4'd9;
      3'd4:    tmax = 4'd12;
      3'd5:    tmax = 4'd15;
      GEAR_R:  tmax = 4'd0;
      default: tmax = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/gear_shift_sequencer_if.sv
// Gear request / pulse bus between gear_ctrl, the shift sequencer and rpm_ctrl.
interface gear_shift_sequencer_if;
  logic [2:0] gear_req;
  logic       accel_pulse_in;
  logic       decel_pulse_in;
  logic [3:0] speed_level;
  logic [2:0] gear_out;
  logic       accel_pulse_out;
  logic       decel_pulse_out;
  logic       shift_busy;
  logic       shift_fault;

  modport master (
    output gear_req, accel_pulse_in, decel_pulse_in, speed_level,
    input  gear_out, accel_pulse_out, decel_pulse_out, shift_busy, shift_fault
  );

  modport slave (
    input  gear_req, accel_pulse_in, decel_pulse_in, speed_level,
    output gear_out, accel_pulse_out, decel_pulse_out, shift_busy, shift_fault
  );
endinterface

// File: rtl/gear_shift_sequencer_timer.sv
// shift_interval_timer: saturating up-counter, cleared by clr_i, with a
// terminal-count strobe at MAX-1 and a zero flag.
module shift_interval_timer #(
  parameter int MAX = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic zero_o
);
  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o   = (cnt_q == LAST);
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/gear_shift_sequencer.sv
// Gear shift sequencer: qualifies gear requests, rev-matches with decel pulses,
// holds an engage window, commits. Option: GEAR_SHIFT_FAULT_LATCH_EN (sticky fault).
module gear_shift_sequencer
  import gear_shift_pkg::*;
#(
  parameter int STABLE_CYCLES  = 20,
  parameter int DECEL_INTERVAL = 50,
  parameter int ENGAGE_CYCLES  = 200,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  gear_shift_sequencer_if.slave bus
);
  state_e     state_q, state_d;
  logic [2:0] cand_q, cand_d, gear_q, gear_d;
  logic       acc_q, acc_d, dec_q, dec_d, busy_q, busy_d, fault_q, fault_d;

  logic stab_tc, stab_zero, iv_tc, iv_zero, to_tc, to_zero, eng_tc, eng_zero;
  logic unused_zero;
  logic stab_reload, fault_set, commit;

  logic [2:0] eff_req;
  logic       no_req, speed_ok, ua, ud;

  // An invalid request code means "keep the current gear".
  assign eff_req  = (bus.gear_req == GEAR_INVALID) ? gear_q : bus.gear_req;
  assign no_req   = (eff_req == gear_q);
  assign speed_ok = (bus.speed_level <= tmax(cand_q));
  assign ua       = bus.accel_pulse_in & ~bus.decel_pulse_in;
  assign ud       = bus.decel_pulse_in & ~bus.accel_pulse_in;

  shift_interval_timer #(.MAX(STABLE_CYCLES)) u_stab (
    .clk(clk), .rst(rst), .clr_i(state_q != QUALIFY || stab_reload),
    .en_i(1'b1), .tc_o(stab_tc), .zero_o(stab_zero));

  shift_interval_timer #(.MAX(DECEL_INTERVAL)) u_iv (
    .clk(clk), .rst(rst), .clr_i(state_q != REV_MATCH || iv_tc),
    .en_i(1'b1), .tc_o(iv_tc), .zero_o(iv_zero));

  shift_interval_timer #(.MAX(TIMEOUT_CYCLES)) u_to (
    .clk(clk), .rst(rst), .clr_i(state_q != REV_MATCH),
    .en_i(1'b1), .tc_o(to_tc), .zero_o(to_zero));

  shift_interval_timer #(.MAX(ENGAGE_CYCLES)) u_eng (
    .clk(clk), .rst(rst), .clr_i(state_q != ENGAGE),
    .en_i(1'b1), .tc_o(eng_tc), .zero_o(eng_zero));

  assign unused_zero = stab_zero ^ to_zero ^ eng_zero;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    gear_d      = gear_q;
    stab_reload = 1'b0;
    fault_set   = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: if (!no_req) begin
        state_d = QUALIFY;
        cand_d  = bus.gear_req;
      end
      QUALIFY: begin
        if (eff_req != cand_q) begin
          if (no_req) state_d = IDLE;
          else begin
            cand_d      = bus.gear_req;
            stab_reload = 1'b1;
          end
        end else if (stab_tc) begin
          state_d = speed_ok ? ENGAGE : REV_MATCH;
        end
      end
      // Exit priority: speed match, then request change, then timeout.
      REV_MATCH: begin
        if (speed_ok) state_d = ENGAGE;
        else if (eff_req != cand_q) begin
          if (no_req) state_d = IDLE;
          else begin
            state_d = QUALIFY;
            cand_d  = bus.gear_req;
          end
        end else if (to_tc) begin
          state_d   = IDLE;
          fault_set = 1'b1;
        end
      end
      ENGAGE: if (eng_tc) begin
        state_d = IDLE;
        gear_d  = cand_q;
        commit  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = 1'b0;
    dec_d = 1'b0;
    case (state_q)
      IDLE, QUALIFY: begin
        acc_d = ua;
        dec_d = ud;
      end
      REV_MATCH: dec_d = ud | (iv_zero && state_d == REV_MATCH);
      default: ;
    endcase
    // Gate by the state the registered pulse will coincide with.
    if (state_d == ENGAGE) begin
      acc_d = 1'b0;
      dec_d = 1'b0;
    end
    if (state_d == REV_MATCH) acc_d = 1'b0;

    busy_d = (state_d == REV_MATCH) || (state_d == ENGAGE);
`ifdef GEAR_SHIFT_FAULT_LATCH_EN
    fault_d = (fault_q | fault_set) & ~commit;
`else
    fault_d = fault_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= GEAR_N;
      gear_q  <= GEAR_N;
      acc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      gear_q  <= gear_d;
      acc_q   <= acc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign bus.gear_out        = gear_q;
  assign bus.accel_pulse_out = acc_q;
  assign bus.decel_pulse_out = dec_q;
  assign bus.shift_busy      = busy_q;
  assign bus.shift_fault     = fault_q;
endmodule

// File: tb/tb_gear_shift_sequencer.sv
// Bench for gear_shift_sequencer: expected output vectors are queued per cycle
// as stimulus is driven and compared on the falling edge of that cycle.
module tb_gear_shift_sequencer;
  localparam int STB = 4, DIV = 3, ENG = 8, TMO = 40;
`ifdef GEAR_SHIFT_FAULT_LATCH_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gear_shift_sequencer_if bus();

  gear_shift_sequencer #(
    .STABLE_CYCLES(STB), .DECEL_INTERVAL(DIV),
    .ENGAGE_CYCLES(ENG), .TIMEOUT_CYCLES(TMO)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  // {gear_out[2:0], accel_out, decel_out, busy, fault}
  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  task automatic push(input int c, input string tag, input logic [2:0] g,
                      input bit a, input bit d, input bit b, input bit f);
    exp_t e;
    e.cyc = c; e.tag = tag; e.v = {g, a, d, b, f};
    sb.push_back(e);
  endtask

  task automatic pushr(input int c0, input int c1, input string tag, input logic [2:0] g,
                       input bit a, input bit d, input bit b, input bit f);
    for (int c = c0; c <= c1; c++) push(c, tag, g, a, d, b, f);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_mon = sb.pop_front();
      if (e_mon.cyc != cyc) chk({e_mon.tag, "_skipped"}, 32'(cyc), 32'(e_mon.cyc));
      else chk(e_mon.tag, {25'd0, bus.gear_out, bus.accel_pulse_out, bus.decel_pulse_out,
                           bus.shift_busy, bus.shift_fault}, {25'd0, e_mon.v});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int k, m, p, q, s, ev;

  initial begin
    bus.gear_req = 3'd0; bus.accel_pulse_in = 1'b0; bus.decel_pulse_in = 1'b0;
    bus.speed_level = 4'd0;
    tick(2);
    push(cyc, "reset", 3'd0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(2);

    // Plain shift N->2, no rev-match; accel held through ENGAGE is blocked.
    k = cyc;
    bus.gear_req = 3'd2; bus.speed_level = 4'd2;
    pushr(k + 1, k + 4, "s1_qualify", 3'd0, 0, 0, 0, 0);
    pushr(k + 5, k + 12, "s1_engage", 3'd0, 0, 0, 1, 0);
    push(k + 13, "s1_commit", 3'd2, 0, 0, 0, 0);
    tick(5); bus.accel_pulse_in = 1'b1;
    tick(7); bus.accel_pulse_in = 1'b0;
    tick(2);

    // Commit gear 4, then downshift to 1 from speed 12 with rev-match.
    k = cyc;
    bus.gear_req = 3'd4;
    push(k + 13, "s2_gear4", 3'd4, 0, 0, 0, 0);
    tick(13);
    m = cyc;
    bus.speed_level = 4'd12; bus.gear_req = 3'd1;
    ev = m + 5;
    pushr(m + 1, m + 4, "s2_qualify", 3'd4, 0, 0, 0, 0);
    push(ev, "s2_rev_entry", 3'd4, 0, 0, 1, 0);
    for (int j = 1; j <= 7; j++) push(ev + j, "s2_rev_decel", 3'd4, 0, (j % 3 == 1), 1, 0);
    pushr(m + 13, m + 20, "s2_engage", 3'd4, 0, 0, 1, 0);
    push(m + 21, "s2_commit", 3'd1, 0, 0, 0, 0);
    tick(5); bus.accel_pulse_in = 1'b1;
    tick(7); bus.speed_level = 4'd3;
    tick(1); bus.accel_pulse_in = 1'b0;
    tick(9);

    // Pass-through in IDLE, including simultaneous accel+decel.
    k = cyc;
    bus.accel_pulse_in = 1'b1; bus.decel_pulse_in = 1'b1;
    push(k + 1, "s3_both", 3'd1, 0, 0, 0, 0);
    push(k + 2, "s3_accel", 3'd1, 1, 0, 0, 0);
    push(k + 3, "s3_decel", 3'd1, 0, 1, 0, 0);
    push(k + 4, "s3_quiet", 3'd1, 0, 0, 0, 0);
    tick(1); bus.decel_pulse_in = 1'b0;
    tick(1); bus.accel_pulse_in = 1'b0; bus.decel_pulse_in = 1'b1;
    tick(1); bus.decel_pulse_in = 1'b0;
    tick(2);

    // Get to gear 2, then a 2,3,2 bounce must abort without shifting.
    k = cyc;
    bus.gear_req = 3'd2;
    push(k + 13, "s4_gear2", 3'd2, 0, 0, 0, 0);
    tick(13);
    p = cyc;
    pushr(p + 1, p + 14, "s4_bounce", 3'd2, 0, 0, 0, 0);
    bus.gear_req = 3'd3;
    tick(1); bus.gear_req = 3'd2;
    tick(15);

    // Reverse requested at speed 10: rev-match times out after 40 cycles.
    q = cyc;
    bus.speed_level = 4'd10; bus.gear_req = 3'd6;
    ev = q + 5;
    pushr(q + 1, q + 4, "s5_qualify", 3'd2, 0, 0, 0, 0);
    for (int j = 0; j < TMO; j++)
      push(ev + j, "s5_rev", 3'd2, 0, (j >= 1 && (j - 1) % DIV == 0), 1, 0);
    push(ev + TMO, "s5_fault", 3'd2, 0, 0, 0, 1);
    push(ev + TMO + 1, "s5_after", 3'd2, 0, 0, 0, FLT);
    tick(5 + TMO); bus.gear_req = 3'd7;
    tick(3);

    // Reset in the middle of ENGAGE.
    s = cyc;
    bus.gear_req = 3'd3; bus.speed_level = 4'd0;
    push(s + 7, "s6_engage", 3'd2, 0, 0, 1, FLT);
    push(s + 8, "s6_reset", 3'd0, 0, 0, 0, 0);
    push(s + 9, "s6_idle", 3'd0, 0, 0, 0, 0);
    tick(7); rst = 1'b1; bus.accel_pulse_in = 1'b1;
    tick(1); rst = 1'b0; bus.accel_pulse_in = 1'b0; bus.gear_req = 3'd0;
    tick(3);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
